gray_counter_conv: RTL

Parametrised, registered Gray-code counter. Generalises our 4-bit binary-to-Gray converter to any width, and adds the following:
- up/down counting and enable;
- loading a Gray-coded value, converted back to binary internally;
- wrap or saturate mode;
- terminal-count and wrap flags.

It produces Gray and binary views of one count from the same clock edge. It is the pointer/sequence source for clock-domain-crossing FIFOs and encoder-position logic.

---
 rtl/gray_counter_conv.sv | 79 +++++++
 1 files changed

// File: rtl/gray_counter_conv.sv
//------------------------------------------------------------------------------
// gray_counter_conv : registered up/down Gray counter with binary view, Gray
// load, wrap/saturate modes, terminal-count and wrap flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gray_counter_conv #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_RESET_B = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] C_RESET_G = C_RESET_B ^ (C_RESET_B >> 1);
  localparam logic [WIDTH-1:0] C_MAX     = '1;

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_b;
  logic             would_wrap;

  // Gray-to-binary: each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    load_b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_b[i] = ^(load_g >> i);
    end
  end

  assign would_wrap = up_dn ? (b_q == C_MAX) : (b_q == '0);

  always_comb begin
    b_d    = b_q;
    g_d    = g_q;
    wrap_d = 1'b0;
    if (load) begin
      b_d = load_b;
      g_d = load_g;
    end else if (en && !(SATURATE && would_wrap)) begin
      b_d    = up_dn ? (b_q + 1'b1) : (b_q - 1'b1);
      // Gray is registered from the next binary value so g never glitches.
      g_d    = b_d ^ (b_d >> 1);
      wrap_d = would_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= C_RESET_B;
      g_q    <= C_RESET_G;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign b    = b_q;
  assign g    = g_q;
  assign wrap = wrap_q;
  assign tc   = would_wrap;

endmodule

`default_nettype wire
